// File: rtl/msx_key_matrix_ctrl_if.sv
// Signal bundle between the MSX key-matrix controller, the scancode translator
// and the PPI port-B read path.
interface msx_key_matrix_ctrl_if;
    // rx_valid is a one-cycle strobe with no ready: every byte presented with
    // rx_valid high is consumed on that clock edge, one byte per clock at most.
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] map_code;
    logic       map_e0;
    logic [6:0] map_key;
    logic [3:0] row_sel;
    logic [7:0] row_data;
    logic       key_event;

    modport slave (
        input  rx_valid, rx_data, map_key, row_sel,
        output map_code, map_e0, row_data, key_event
    );

    modport master (
        output rx_valid, rx_data, map_key, row_sel,
        input  map_code, map_e0, row_data, key_event
    );
endinterface

// File: rtl/msx_key_matrix_ctrl.sv
// PS/2 byte-stream parser feeding an external scancode translator, plus the
// active-low MSX keyboard matrix it updates and the registered row read path.
module msx_key_matrix_ctrl #(
    parameter int NUM_ROWS         = 11,
    parameter int E1_SKIP          = 7,
    parameter bit CLEAR_ON_OVERRUN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    msx_key_matrix_ctrl_if.slave  bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

    state_t     state, state_n;
    logic [7:0] skip_cnt, skip_cnt_n;
    logic       issue, issue_make, issue_e0, clear_all;

    logic [7:0] code_q;
    logic       e0_q, s2_make, s2_valid, clr_pend;
    logic       apply_v, apply_make;
    logic [6:0] apply_key;

    logic [7:0] mtx   [NUM_ROWS];
    logic [7:0] mtx_n [NUM_ROWS];
    logic       event_n, key_event_q;
    logic [7:0] rd_n, row_data_q;

    always_comb begin
        state_n    = state;
        skip_cnt_n = skip_cnt;
        issue      = 1'b0;
        issue_make = 1'b1;
        issue_e0   = 1'b0;
        clear_all  = 1'b0;
        if (bus.rx_valid) begin
            unique case (state)
                S_IDLE: begin
                    case (bus.rx_data)
                        8'hE0: state_n = S_EXT;
                        8'hF0: state_n = S_BRK;
                        8'hE1: begin
                            state_n    = (E1_SKIP == 0) ? S_IDLE : S_SKIP;
                            skip_cnt_n = 8'(E1_SKIP);
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
                        8'h00, 8'hFF: clear_all = CLEAR_ON_OVERRUN;
                        default: issue = 1'b1;
                    endcase
                end
                S_EXT: begin
                    state_n = S_IDLE;
                    // E0 12 / E0 59 are the fake shifts wrapped around extended keys
                    if (bus.rx_data == 8'hF0) begin
                        state_n = S_EXT_BRK;
                    end else if (bus.rx_data != 8'h12 && bus.rx_data != 8'h59) begin
                        issue    = 1'b1;
                        issue_e0 = 1'b1;
                    end
                end
                S_BRK: begin
                    state_n    = S_IDLE;
                    issue      = 1'b1;
                    issue_make = 1'b0;
                end
                S_EXT_BRK: begin
                    state_n = S_IDLE;
                    if (bus.rx_data != 8'h12 && bus.rx_data != 8'h59) begin
                        issue      = 1'b1;
                        issue_make = 1'b0;
                        issue_e0   = 1'b1;
                    end
                end
                S_SKIP: begin
                    skip_cnt_n = skip_cnt - 8'd1;
                    if (skip_cnt <= 8'd1) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            skip_cnt   <= '0;
            code_q     <= '0;
            e0_q       <= 1'b0;
            s2_make    <= 1'b0;
            s2_valid   <= 1'b0;
            clr_pend   <= 1'b0;
            apply_v    <= 1'b0;
            apply_make <= 1'b0;
            apply_key  <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_cnt_n;
            s2_valid <= issue;
            clr_pend <= clear_all;
            if (issue) begin
                code_q  <= bus.rx_data;
                e0_q    <= issue_e0;
                s2_make <= issue_make;
            end
            // translator result is captured one cycle after the code is presented
            apply_v <= s2_valid;
            if (s2_valid) begin
                apply_key  <= bus.map_key;
                apply_make <= s2_make;
            end
        end
    end

    // clear first, then a same-cycle key update overrides it
    always_comb begin
        event_n = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            mtx_n[r] = clr_pend ? 8'hFF : mtx[r];
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (apply_v && apply_key[6:3] == 4'(r)) begin
                mtx_n[r][apply_key[2:0]] = ~apply_make;
                event_n = (mtx[r][apply_key[2:0]] != ~apply_make);
            end
        end
    end

    always_comb begin
        rd_n = 8'hFF;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (bus.row_sel == 4'(r)) rd_n = mtx[r];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_ROWS; r++) mtx[r] <= 8'hFF;
            key_event_q <= 1'b0;
            row_data_q  <= 8'hFF;
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) mtx[r] <= mtx_n[r];
            key_event_q <= event_n;
            row_data_q  <= rd_n;
        end
    end

    assign bus.map_code  = code_q;
    assign bus.map_e0    = e0_q;
    assign bus.key_event = key_event_q;
    assign bus.row_data  = row_data_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_msx_key_matrix_ctrl.sv
// Bench for msx_key_matrix_ctrl: directed scenarios plus random PS/2 traffic,
// checked cycle by cycle against a key-level reference model.
module tb_msx_key_matrix_ctrl;
  localparam int NUM_ROWS = 11;
  localparam int E1_SKIP  = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  msx_key_matrix_ctrl_if bus();

  msx_key_matrix_ctrl #(.NUM_ROWS(NUM_ROWS), .E1_SKIP(E1_SKIP), .CLEAR_ON_OVERRUN(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- translator stand-in ----------------
  function automatic logic [6:0] xlate(input logic [7:0] c, input logic e0);
    logic [6:0] k;
    k = c[6:0] ^ {e0, 6'd0};
    if (c[7]) k = 7'h78;
    case ({e0, c})
      9'h01C: k = {4'd2, 3'd6};
      9'h175: k = {4'd8, 3'd5};
      9'h075: k = {4'd10, 3'd3};
      9'h016: k = {4'd0, 3'd1};
      9'h012, 9'h059: k = 7'h30;
      9'h114, 9'h111, 9'h12F: k = 7'h34;
      9'h014: k = 7'h31;
      9'h074: k = {4'd10, 3'd1};
      9'h174: k = {4'd8, 3'd7};
      9'h077: k = 7'h78;
      default: ;
    endcase
    return k;
  endfunction

  always_comb bus.map_key = xlate(bus.map_code, bus.map_e0);

  // ---------------- reference model ----------------
  typedef struct { int due; bit is_clear; bit make; logic [6:0] key; } act_t;
  act_t       sched[$];
  bit         pressed [128];
  bit         p_e0, p_brk;
  int         p_skip;
  logic [7:0] m_code;
  logic       m_code_e0;
  int         edge_no = 0;
  logic [3:0] cur_sel = 4'd0;

  task automatic model_reset();
    foreach (pressed[k]) pressed[k] = 1'b0;
    sched.delete();
    p_e0 = 0; p_brk = 0; p_skip = 0;
    m_code = 8'h00; m_code_e0 = 1'b0;
  endtask

  function automatic logic [7:0] model_row(input logic [3:0] sel);
    logic [7:0] v;
    v = 8'hFF;
    if (sel < NUM_ROWS)
      for (int c = 0; c < 8; c++) v[c] = ~pressed[{sel, 3'(c)}];
    return v;
  endfunction

  task automatic model_issue(input logic [7:0] d, input logic e0, input bit mk);
    act_t a;
    m_code = d; m_code_e0 = e0;
    a.due = edge_no + 2; a.is_clear = 0; a.make = mk; a.key = xlate(d, e0);
    sched.push_back(a);
  endtask

  task automatic model_byte(input logic [7:0] d);
    act_t a;
    if (p_skip > 0) begin
      p_skip--;
    end else if (!p_e0 && !p_brk) begin
      case (d)
        8'hE0: p_e0 = 1;
        8'hF0: p_brk = 1;
        8'hE1: p_skip = E1_SKIP;
        8'hAA, 8'hFA, 8'hEE, 8'hFE: ;
        8'h00, 8'hFF: begin
          a.due = edge_no + 1; a.is_clear = 1; a.make = 0; a.key = '0;
          sched.push_back(a);
        end
        default: model_issue(d, 1'b0, 1'b1);
      endcase
    end else if (p_e0 && !p_brk && d == 8'hF0) begin
      p_brk = 1;
    end else begin
      if (!(p_e0 && (d == 8'h12 || d == 8'h59))) model_issue(d, p_e0, !p_brk);
      p_e0 = 0; p_brk = 0;
    end
  endtask

  task automatic model_edge(output logic ev);
    act_t keep[$];
    act_t op;
    bit   do_clr, do_op, old;
    do_clr = 0; do_op = 0; ev = 0; old = 0;
    op.due = 0; op.is_clear = 0; op.make = 0; op.key = '0;
    foreach (sched[i]) begin
      if (sched[i].due == edge_no) begin
        if (sched[i].is_clear) do_clr = 1;
        else begin do_op = 1; op = sched[i]; end
      end else keep.push_back(sched[i]);
    end
    sched = keep;
    if (do_op) old = pressed[op.key];
    if (do_clr) foreach (pressed[k]) pressed[k] = 1'b0;
    if (do_op && op.key[6:3] < NUM_ROWS) begin
      pressed[op.key] = op.make;
      ev = (old != op.make);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  int n_checks = 0, n_pass = 0, ev_seen = 0, ev_base = 0, mon_no = 0;

  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic [7:0] exp_row;
    logic       exp_ev;
    @(negedge clk);
    reset = r; bus.rx_valid = v; bus.rx_data = d; bus.row_sel = cur_sel;
    if (r) begin
      model_reset();
      exp_q.push_back({1'b0, 8'hFF, 8'h00, 1'b0});
    end else begin
      exp_row = model_row(cur_sel);
      model_edge(exp_ev);
      if (v) model_byte(d);
      exp_q.push_back({exp_ev, exp_row, m_code, m_code_e0});
    end
    edge_no++;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_ev(input string name, input int want);
    @(posedge clk); #2;
    n_checks++;
    if (ev_seen - ev_base == want) n_pass++;
    else $display("FAIL %s key_event count: got %0d, expected %0d", name, ev_seen - ev_base, want);
    ev_base = ev_seen;
  endtask

  always begin
    logic [17:0] got, e;
    @(posedge clk); #1;
    mon_no++;
    if (exp_q.size() > 0) begin
      got = {bus.key_event, bus.row_data, bus.map_code, bus.map_e0};
      e = exp_q.pop_front();
      n_checks++;
      if (got === e) n_pass++;
      else $display("FAIL edge_check cycle %0d sel=%0d: got ev=%b row=%h code=%h e0=%b, expected ev=%b row=%h code=%h e0=%b",
                    mon_no, bus.row_sel, got[17], got[16:9], got[8:1], got[0], e[17], e[16:9], e[8:1], e[0]);
    end
    if (bus.key_event === 1'b1) ev_seen++;
  end

  // ---------------- stimulus ----------------
  logic [7:0] key_pool [10] = '{8'h1C, 8'h12, 8'h59, 8'h75, 8'h74, 8'h16, 8'h14, 8'h11, 8'h2F, 8'h77};
  logic [7:0] ctl_pool [4]  = '{8'hAA, 8'hFA, 8'hEE, 8'hFE};

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 10) return 8'hE0;
    if (r < 20) return 8'hF0;
    if (r < 22) return 8'hE1;
    if (r < 26) return ctl_pool[$urandom_range(0, 3)];
    if (r < 28) return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
    if (r < 50) return key_pool[$urandom_range(0, 9)];
    return 8'($urandom_range(1, 127));
  endfunction

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.row_sel = 4'd0;
    model_reset();
    #7;
    n_checks++;
    if (bus.map_code === 8'h00 && bus.map_e0 === 1'b0 && bus.row_data === 8'hFF &&
        bus.key_event === 1'b0 && dbg_state === 3'd0) n_pass++;
    else $display("FAIL reset_state: got code=%h e0=%b row=%h ev=%b st=%0d, expected 00 0 ff 0 0",
                  bus.map_code, bus.map_e0, bus.row_data, bus.key_event, dbg_state);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    idle(2);

    // A press and release
    cur_sel = 4'd2;
    send(8'h1C); idle(3); send(8'hF0); send(8'h1C); idle(3);
    check_ev("a_press_release", 2);

    // Up arrow vs keypad 8
    cur_sel = 4'd8;
    send(8'hE0); send(8'h75); idle(2); send(8'hE0); send(8'hF0); send(8'h75); idle(2);
    cur_sel = 4'd10;
    send(8'h75); idle(2); send(8'hF0); send(8'h75); idle(3);
    check_ev("up_and_kp8", 4);

    // Pause sequence is swallowed
    cur_sel = 4'd0;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
    send(8'h14); send(8'hF0); send(8'h77); send(8'h16); idle(3);
    check_ev("pause_then_16", 1);
    send(8'hF0); send(8'h16); idle(3);
    check_ev("release_16", 1);

    // shared shift, then overrun clear, then clear colliding with an update
    cur_sel = 4'd6;
    send(8'h12); idle(1); send(8'h59); idle(1); send(8'hF0); send(8'h59); idle(3);
    check_ev("shared_shift", 2);
    send(8'h12); idle(1); send(8'h1C); idle(1); send(8'hFF); idle(3);
    check_ev("overrun_clear", 2);
    cur_sel = 4'd2;
    send(8'h1C); send(8'hFF); idle(3);
    check_ev("clear_vs_update", 1);
    send(8'hF0); send(8'h1C); idle(3);
    check_ev("clear_vs_update_rel", 1);

    // typematic repeats with an out-of-range row selected
    cur_sel = 4'd11;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); idle(3);
    check_ev("typematic", 2);

    // reset while in the extended-break state with keys held
    cur_sel = 4'd10;
    send(8'h1C); send(8'h12); idle(3); send(8'hE0); send(8'hF0);
    step(1'b0, 8'h00, 1'b1); step(1'b0, 8'h00, 1'b1);
    send(8'h74); idle(3);
    check_ev("reset_mid_ext_brk", 3);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cur_sel = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) step(1'b0, 8'h00, 1'b1);
      else step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, pick_byte(), 1'b0);
    end
    idle(4);
    @(posedge clk); #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
